// File: rtl/nn_param_chain_loader_pkg.sv
// Shared types, command encodings and chain index helpers for the neuron
// parameter chain loader.
package nn_param_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2,
        StRead = 2'd3
    } state_e;

    // Host command encodings
    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    // Chain position of weight i of neuron n
    function automatic int unsigned w_idx(input int unsigned n, input int unsigned i,
                                          input int unsigned n_inputs = 4);
        return n * (n_inputs + 2) + i;
    endfunction

    // Chain position of the bias of neuron n
    function automatic int unsigned b_idx(input int unsigned n,
                                          input int unsigned n_inputs = 4);
        return n * (n_inputs + 2) + n_inputs;
    endfunction

    // Chain position of the threshold of neuron n
    function automatic int unsigned th_idx(input int unsigned n,
                                           input int unsigned n_inputs = 4);
        return n * (n_inputs + 2) + n_inputs + 1;
    endfunction

endpackage

// File: rtl/nn_param_chain_loader_if.sv
// Host word interface of the parameter loader: command, serial word
// handshake and readback stream.
interface nn_param_chain_loader_if #(
    parameter int unsigned DATA_W = 8
);
    logic [1:0]        cmd;
    logic [DATA_W-1:0] data_in;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output cmd, data_in, in_valid,
        input  in_ready, rd_data, rd_valid
    );

    modport slave (
        input  cmd, data_in, in_valid,
        output in_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/nn_param_chain_loader_chain.sv
// Parameter shift chain: words enter at the tail and move toward index 0;
// rotation feeds the head word back into the tail.
module nn_param_chain #(
    parameter int unsigned DEPTH  = 24,
    parameter int unsigned DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    shift_en,
    input  logic                    rotate_en,
    input  logic [DATA_W-1:0]       din,
    output logic [DEPTH*DATA_W-1:0] q
);
    logic [DATA_W-1:0] c_q [DEPTH];

    // Shift or rotate the whole chain by one word; hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                c_q[k] <= '0;
            end
        end else if (shift_en || rotate_en) begin
            for (int k = 0; k < int'(DEPTH) - 1; k++) begin
                c_q[k] <= c_q[k+1];
            end
            c_q[DEPTH-1] <= rotate_en ? c_q[0] : din;
        end
    end

    for (genvar k = 0; k < int'(DEPTH); k++) begin : g_tap
        assign q[k*DATA_W +: DATA_W] = c_q[k];
    end

endmodule

// File: rtl/nn_param_chain_loader.sv
// Serial loader for a layer's neuron parameter store (weights, bias,
// threshold). Optional non-destructive readback is built when the macro
// NN_PARAM_READBACK_EN is defined.
module nn_param_chain_loader
    import nn_param_pkg::*;
#(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned N_INPUTS  = 4,
    parameter int unsigned DATA_W    = 8,
    localparam int unsigned REC      = N_INPUTS + 2,
    localparam int unsigned TOTAL    = N_NEURONS * REC,
    localparam int unsigned CNT_W    = $clog2(TOTAL + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    nn_param_chain_loader_if.slave              bus,
    output logic [N_NEURONS*N_INPUTS*DATA_W-1:0] weights,
    output logic [N_NEURONS*DATA_W-1:0]         bias,
    output logic [N_NEURONS*DATA_W-1:0]         thresh,
    output logic                                params_valid,
    output logic                                busy,
    output logic [CNT_W-1:0]                    load_count,
    output logic                                err_overrun
);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TOTAL - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   load_count_q;
    logic               in_ready_q;
    logic               busy_q;
    logic               params_valid_q;
    logic               err_overrun_q;
    logic               shift_en;
    logic               rotate_en;
    logic [TOTAL*DATA_W-1:0] chain_q;

`ifdef NN_PARAM_READBACK_EN
    localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL);
    logic [DATA_W-1:0]  rd_data_q;
    logic               rd_valid_q;
    logic [CNT_W-1:0]   rd_cnt_q;
`endif

    // A word is taken only in LOAD and only when no restart/abort is issued
    assign shift_en = (state_q == StLoad) && bus.in_valid &&
                      (bus.cmd != CMD_LOAD) && (bus.cmd != CMD_ABORT);

`ifdef NN_PARAM_READBACK_EN
    // The first rotation coincides with the read command so rd_data lands a cycle later
    assign rotate_en = ((state_q == StDone) && (bus.cmd == CMD_READ)) ||
                       ((state_q == StRead) && (rd_cnt_q != TOTAL_CNT) &&
                        (bus.cmd != CMD_ABORT));
`else
    assign rotate_en = 1'b0;
`endif

    nn_param_chain #(
        .DEPTH  (TOTAL),
        .DATA_W (DATA_W)
    ) u_chain (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en),
        .rotate_en (rotate_en),
        .din       (bus.data_in),
        .q         (chain_q)
    );

    // FSM, word counter and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            load_count_q   <= '0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            params_valid_q <= 1'b0;
            err_overrun_q  <= 1'b0;
`ifdef NN_PARAM_READBACK_EN
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            rd_cnt_q       <= '0;
`endif
        end else begin
            // Sticky overrun flag, cleared by a new load command
            if (bus.cmd == CMD_LOAD) begin
                err_overrun_q <= 1'b0;
            end else if (bus.in_valid && !in_ready_q) begin
                err_overrun_q <= 1'b1;
            end
`ifdef NN_PARAM_READBACK_EN
            rd_valid_q <= 1'b0;
`endif
            if (bus.cmd == CMD_ABORT) begin
                state_q        <= StIdle;
                load_count_q   <= '0;
                in_ready_q     <= 1'b0;
                busy_q         <= 1'b0;
                params_valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.cmd == CMD_LOAD) begin
                            state_q      <= StLoad;
                            load_count_q <= '0;
                            in_ready_q   <= 1'b1;
                            busy_q       <= 1'b1;
                        end
                    end
                    StLoad: begin
                        if (bus.cmd == CMD_LOAD) begin
                            load_count_q <= '0;
                        end else if (bus.in_valid) begin
                            load_count_q <= load_count_q + 1'b1;
                            if (load_count_q == LAST_CNT) begin
                                state_q        <= StDone;
                                in_ready_q     <= 1'b0;
                                busy_q         <= 1'b0;
                                params_valid_q <= 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        if (bus.cmd == CMD_LOAD) begin
                            state_q        <= StLoad;
                            load_count_q   <= '0;
                            in_ready_q     <= 1'b1;
                            busy_q         <= 1'b1;
                            params_valid_q <= 1'b0;
                        end
`ifdef NN_PARAM_READBACK_EN
                        else if (bus.cmd == CMD_READ) begin
                            state_q        <= StRead;
                            busy_q         <= 1'b1;
                            params_valid_q <= 1'b0;
                            rd_data_q      <= chain_q[DATA_W-1:0];
                            rd_valid_q     <= 1'b1;
                            rd_cnt_q       <= CNT_W'(1);
                        end
`endif
                    end
`ifdef NN_PARAM_READBACK_EN
                    StRead: begin
                        // After TOTAL rotations the chain is back in load order
                        if (rd_cnt_q == TOTAL_CNT) begin
                            state_q        <= StDone;
                            busy_q         <= 1'b0;
                            params_valid_q <= 1'b1;
                        end else begin
                            rd_data_q  <= chain_q[DATA_W-1:0];
                            rd_valid_q <= 1'b1;
                            rd_cnt_q   <= rd_cnt_q + 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready = in_ready_q;
    assign params_valid = params_valid_q;
    assign busy         = busy_q;
    assign load_count   = load_count_q;
    assign err_overrun  = err_overrun_q;

`ifdef NN_PARAM_READBACK_EN
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`else
    assign bus.rd_data  = '0;
    assign bus.rd_valid = 1'b0;
`endif

    // Parameter buses are direct taps of the chain
    for (genvar n = 0; n < int'(N_NEURONS); n++) begin : g_neuron
        for (genvar i = 0; i < int'(N_INPUTS); i++) begin : g_weight
            localparam int unsigned WI = w_idx(n, i, N_INPUTS);
            assign weights[(n*N_INPUTS+i)*DATA_W +: DATA_W] = chain_q[WI*DATA_W +: DATA_W];
        end
        localparam int unsigned BI = b_idx(n, N_INPUTS);
        localparam int unsigned TI = th_idx(n, N_INPUTS);
        assign bias[n*DATA_W +: DATA_W]   = chain_q[BI*DATA_W +: DATA_W];
        assign thresh[n*DATA_W +: DATA_W] = chain_q[TI*DATA_W +: DATA_W];
    end

endmodule
